ram_burst_reader: RTL

Read-side initiator for the synchronous-read RAM primitives (simple dual-port, registered read port).
- Accepts a burst command (base address, length) and issues sequential reads on the RAM read port.
- Re-times the returning data into a valid/ready stream with last-beat marking.
- Absorbs RAM read latency behind an internal credit-controlled buffer, so downstream back-pressure never loses data.

---
 rtl/ram_burst_reader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ram_burst_reader.sv
// Burst read initiator for registered-read RAMs: sequential reads, credit-limited return FIFO, valid/ready output stream.
// Define RAM_RD_OREG_EN for RAMs with an extra output register (read latency 2, FIFO depth 4).
module ram_burst_reader #(
  parameter int DW    = 8,
  parameter int WORDS = 256,
  parameter int LW    = $clog2(WORDS) + 1,
  localparam int AW   = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rd_addr,
  output logic          rd_en,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last
);

`ifdef RAM_RD_OREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif
  localparam int DEPTH = RD_LAT + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state;
  logic [LW-1:0]     iss_left, beats_left;
  logic [RD_LAT-1:0] vld_pipe;
  logic [DW-1:0]     fifo [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     occ;
  logic [CW:0]       committed;
  logic              push, pop, room;

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == AW'(WORDS - 1)) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push    = vld_pipe[RD_LAT-1];
  assign m_valid = (occ != '0);
  assign pop     = m_valid & m_ready;
  assign m_data  = m_valid ? fifo[rd_ptr] : '0;
  assign m_last  = m_valid && (beats_left == LW'(1));

  // FIFO slots already spoken for once this edge retires: stored words plus every
  // read still travelling through the RAM, minus the word leaving now.
  always_comb begin
    committed = (CW+1)'(occ) + (CW+1)'(rd_en);
    for (int i = 0; i < RD_LAT; i++) committed = committed + (CW+1)'(vld_pipe[i]);
    committed = committed - (CW+1)'(pop);
  end
  assign room = committed < (CW+1)'(DEPTH);

  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= rd_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      iss_left   <= '0;
      beats_left <= '0;
      vld_pipe   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
    end else begin
      done        <= 1'b0;
      vld_pipe[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr     <= ptr_inc(rd_ptr);
        beats_left <= beats_left - 1'b1;
      end
      occ <= occ + CW'(push) - CW'(pop);
      case (state)
        IDLE: begin
          rd_en <= 1'b0;
          if (start) begin
            if (len == '0) done <= 1'b1;
            else begin
              state      <= RUN;
              busy       <= 1'b1;
              rd_en      <= 1'b1;
              rd_addr    <= base_addr;
              iss_left   <= len - 1'b1;
              beats_left <= len;
            end
          end
        end
        RUN: begin
          if (iss_left == '0) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else if (room) begin
            rd_en    <= 1'b1;
            rd_addr  <= addr_inc(rd_addr);
            iss_left <= iss_left - 1'b1;
          end else begin
            rd_en <= 1'b0;
          end
        end
        DRAIN: begin
          rd_en <= 1'b0;
          // Popping the last beat implies the FIFO and the RAM pipe are both empty.
          if (pop && beats_left == LW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
